shift_sequencer: RTL

Multi-cycle 32-bit shift unit for the EX stage of the pipelined datapath. It applies one power-of-two shift stage per clock (16, 8, 4, 2, 1), each gated by one bit of the shift amount. It supports logical right, logical left and arithmetic right shifts. The hazard unit holds the pipeline on `busy` and consumes `out_data` on `done`.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_stage.sv | 28 ++
 rtl/shift_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    localparam int WIDTH = 32;

    // Operation encodings; 2'b11 is treated as SRL by the datapath.
    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Index of the first (largest, 16-bit) shift stage.
    localparam logic [2:0] K_FIRST = 3'd4;

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift stage: shifts data by 2^k in the direction given by op.
// Latency: combinational.
// Backpressure: none.
module shift_stage
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       k,
    input  logic [1:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [4:0]       amt;
    logic [WIDTH-1:0] fill_mask;

    // Left shifts fill with zero; right shifts OR in the fill bit over the vacated top bits.
    always_comb begin
        amt       = 5'd1 << k;
        fill_mask = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
        if (op == OP_SLL) begin
            result = data << amt;
        end else begin
            result = (data >> amt) | fill_mask;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: stages 16/8/4/2/1 applied on successive clocks, gated by shamt bits.
// Latency: done/out_data 6 cycles after the start cycle; one result per 6 cycles back-to-back.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       shamt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data
);

    state_e           state;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       k_q;
    logic [4:0]       shamt_q;
    logic [1:0]       op_q;
    logic             sign_q;

    logic             fill;
    logic [WIDTH-1:0] stage_out;
    logic [WIDTH-1:0] work_next;

    // Sign fill only for SRA; the sign is the operand MSB captured at accept.
    assign fill = (op_q == OP_SRA) ? sign_q : 1'b0;

    shift_stage u_stage (
        .data   (work_q),
        .k      (k_q),
        .op     (op_q),
        .fill   (fill),
        .result (stage_out)
    );

    // Apply the current stage only when its shift-amount bit is set.
    always_comb begin
        work_next = work_q;
        if (shamt_q[k_q]) begin
            work_next = stage_out;
        end
    end

    // Control FSM with registered busy/done/out_data; reset discards any in-flight shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            work_q   <= '0;
            k_q      <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        work_q  <= in_data;
                        shamt_q <= shamt;
                        op_q    <= op;
                        sign_q  <= in_data[WIDTH-1];
                        k_q     <= K_FIRST;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= work_next;
                    if (k_q == 3'd0) begin
                        out_data <= work_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        k_q <= k_q - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
